// File: rtl/ghash_ctrl.sv
// rtl/ghash_ctrl.sv - GHASH sequencer driving an external carry-less multiplier
module ghash_ctrl #(
  parameter int WIDTH    = 128,
  parameter int MAX_WAIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   h_i,
  input  logic               blk_valid_i,
  output logic               blk_ready_o,
  input  logic [WIDTH-1:0]   blk_i,
  input  logic               last_i,
  output logic               mul_valid_o,
  output logic [WIDTH-1:0]   mul_a_o,
  output logic [WIDTH-1:0]   mul_b_o,
  input  logic               mul_valid_i,
  input  logic [2*WIDTH-1:0] mul_result_i,
  output logic               tag_valid_o,
  output logic [WIDTH-1:0]   tag_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WAIT,
    S_REDUCE,
    S_OUT
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]   h_int;
  logic [WIDTH-1:0]   y;
  logic               last_q;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      wait_cnt;
  logic               timeout;
  logic [WIDTH-1:0]   y_reduced;

  // GCM numbers bit 127 as x^0; the multiplier wants bit i = x^i
  function automatic logic [127:0] bitrev128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) begin
      r[i] = v[127-i];
    end
    return r;
  endfunction

  // Two folds of the upper half through x^128 = x^7 + x^2 + x + 1; the
  // second fold only sees the few bits the first fold pushed past x^127.
  function automatic logic [127:0] gf_reduce(input logic [255:0] p);
    logic [134:0] hi;
    logic [134:0] f1;
    logic [13:0]  te;
    logic [13:0]  f2;
    hi = {7'b0, p[255:128]};
    f1 = hi ^ (hi << 1) ^ (hi << 2) ^ (hi << 7);
    te = {7'b0, f1[134:128]};
    f2 = te ^ (te << 1) ^ (te << 2) ^ (te << 7);
    return p[127:0] ^ f1[127:0] ^ {114'b0, f2};
  endfunction

  assign y_reduced = gf_reduce(prod);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_n     = state;
    blk_ready_o = 1'b0;
    busy_o      = 1'b1;
    tag_valid_o = 1'b0;
    timeout     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_n = S_ACCEPT;
      end
      S_ACCEPT: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (mul_valid_i) begin
          state_n = S_REDUCE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_REDUCE: begin
        state_n = last_q ? S_OUT : S_ACCEPT;
      end
      S_OUT: begin
        tag_valid_o = 1'b1;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: subkey latch, operand launch, product capture, accumulator update
  always_ff @(posedge clk) begin
    if (rst) begin
      h_int       <= '0;
      y           <= '0;
      last_q      <= 1'b0;
      prod        <= '0;
      wait_cnt    <= '0;
      mul_valid_o <= 1'b0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      tag_o       <= '0;
      err_o       <= 1'b0;
    end else begin
      mul_valid_o <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            h_int <= bitrev128(h_i);
            y     <= '0;
          end
        end
        S_ACCEPT: begin
          if (blk_valid_i) begin
            mul_a_o     <= y ^ bitrev128(blk_i);
            mul_b_o     <= h_int;
            last_q      <= last_i;
            mul_valid_o <= 1'b1;
            wait_cnt    <= '0;
          end
        end
        S_WAIT: begin
          if (mul_valid_i) begin
            prod <= mul_result_i;
          end else if (timeout) begin
            err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_REDUCE: begin
          y <= y_reduced;
          if (last_q) tag_o <= bitrev128(y_reduced);
        end
        default: ;
      endcase
    end
  end

endmodule
